// File: rtl/debug_pkg.sv
// Shared debug-path definitions: the latch code table walked by the dump
// sequencer, its length, and the sequencer state encoding.
package debug_pkg;

    localparam int N_LATCH_WORDS  = 20;
    localparam int BYTES_PER_WORD = 4;
    localparam int CODE_W         = 7;
    localparam int WORD_IDX_W     = 5;

    // Dump order; code 7'h22 is intentionally absent and must never be driven.
    localparam logic [CODE_W-1:0] LATCH_CODES [N_LATCH_WORDS] = '{
        7'h00, 7'h01,
        7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
        7'h20, 7'h21, 7'h23, 7'h24, 7'h25, 7'h26,
        7'h30, 7'h31, 7'h32, 7'h33,
        7'h40, 7'h41
    };

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        SEND,
        DONE
    } dumpState_e;

    function automatic logic [CODE_W-1:0] latchCode(input logic [WORD_IDX_W-1:0] idx);
        if (idx < WORD_IDX_W'(N_LATCH_WORDS)) begin
            return LATCH_CODES[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/latch_dump_ctrl.sv
// Walks the pipeline latch mux through every latch code and streams each
// captured 32-bit word to the debug UART as four little-endian bytes.
module latch_dump_ctrl
    import debug_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int N_WORDS       = N_LATCH_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [CODE_W-1:0] mux_sel,
    input  logic [31:0]       mux_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0]            SETTLE_LAST = 2'(SETTLE_CYCLES);
    localparam logic [1:0]            LAST_BYTE   = 2'(BYTES_PER_WORD - 1);
    localparam logic [WORD_IDX_W-1:0] LAST_WORD   = WORD_IDX_W'(N_WORDS - 1);

    dumpState_e            state, stateNext;
    logic [WORD_IDX_W-1:0] wordIdx, wordIdxNext, wordIdxInc;
    logic [1:0]            byteCnt, byteCntNext;
    logic [1:0]            settleCnt, settleCntNext;
    logic [31:0]           shiftReg, shiftRegNext;
    logic [CODE_W-1:0]     muxSel, muxSelNext;
    logic                  txValid, txValidNext;
    logic                  doneReg, doneNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wordIdx   <= '0;
            byteCnt   <= '0;
            settleCnt <= '0;
            shiftReg  <= '0;
            muxSel    <= '0;
            txValid   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            wordIdx   <= wordIdxNext;
            byteCnt   <= byteCntNext;
            settleCnt <= settleCntNext;
            shiftReg  <= shiftRegNext;
            muxSel    <= muxSelNext;
            txValid   <= txValidNext;
            doneReg   <= doneNext;
        end
    end

    assign wordIdxInc = wordIdx + WORD_IDX_W'(1);

    always_comb begin
        stateNext     = state;
        wordIdxNext   = wordIdx;
        byteCntNext   = byteCnt;
        settleCntNext = settleCnt;
        shiftRegNext  = shiftReg;
        muxSelNext    = muxSel;
        txValidNext   = txValid;
        doneNext      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    muxSelNext    = latchCode('0);
                    wordIdxNext   = '0;
                    settleCntNext = '0;
                    stateNext     = SELECT;
                end
            end
            SELECT: begin
                // The mux output is registered, so the word is only trusted on the last settle cycle.
                if (settleCnt == SETTLE_LAST) begin
                    shiftRegNext = mux_data;
                    txValidNext  = 1'b1;
                    byteCntNext  = '0;
                    stateNext    = SEND;
                end else begin
                    settleCntNext = settleCnt + 2'd1;
                end
            end
            SEND: begin
                if (txValid && tx_ready) begin
                    if (byteCnt == LAST_BYTE) begin
                        txValidNext = 1'b0;
                        if (wordIdx == LAST_WORD) begin
                            stateNext = DONE;
                        end else begin
                            wordIdxNext   = wordIdxInc;
                            muxSelNext    = latchCode(wordIdxInc);
                            settleCntNext = '0;
                            stateNext     = SELECT;
                        end
                    end else begin
                        shiftRegNext = {8'h00, shiftReg[31:8]};
                        byteCntNext  = byteCnt + 2'd1;
                    end
                end
            end
            DONE: begin
                doneNext   = 1'b1;
                muxSelNext = '0;
                stateNext  = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Abort drops everything back to reset values without a done pulse.
        if (abort && (state != IDLE)) begin
            stateNext     = IDLE;
            wordIdxNext   = '0;
            byteCntNext   = '0;
            settleCntNext = '0;
            shiftRegNext  = '0;
            muxSelNext    = '0;
            txValidNext   = 1'b0;
            doneNext      = 1'b0;
        end
    end

    assign mux_sel  = muxSel;
    assign tx_data  = shiftReg[7:0];
    assign tx_valid = txValid;
    assign busy     = (state != IDLE);
    assign done     = doneReg;

endmodule

// File: tb/tb_latch_dump_ctrl.sv
// Drives two dump controllers (settle 1 and settle 3) against a registered mux
// model and compares the byte stream and timing with a table-driven expectation.
module tb_latch_dump_ctrl;

    localparam int NW     = 20;
    localparam int BUDGET = 2000;

    logic        clk, rst;
    logic        startA, abortA, readyA, validA, busyA, doneA;
    logic [6:0]  selA;
    logic [31:0] dataA;
    logic [7:0]  txA;
    logic        startB, abortB, readyB, validB, busyB, doneB;
    logic [6:0]  selB;
    logic [31:0] dataB;
    logic [7:0]  txB;

    logic [6:0]  codeList [NW];
    logic [31:0] randWords [128];
    logic [7:0]  expBytes [NW*4];
    bit          useRand;
    int          checkCount, passCount, failCount;
    int          firstV, doneN, nBytes;

    latch_dump_ctrl #(.SETTLE_CYCLES(1), .N_WORDS(20)) dutA (
        .clk(clk), .rst(rst), .start(startA), .abort(abortA),
        .mux_sel(selA), .mux_data(dataA), .tx_data(txA), .tx_valid(validA),
        .tx_ready(readyA), .busy(busyA), .done(doneA)
    );

    latch_dump_ctrl #(.SETTLE_CYCLES(3), .N_WORDS(20)) dutB (
        .clk(clk), .rst(rst), .start(startB), .abort(abortB),
        .mux_sel(selB), .mux_data(dataB), .tx_data(txB), .tx_valid(validB),
        .tx_ready(readyB), .busy(busyB), .done(doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] muxWord(input logic [6:0] sel);
        if (useRand) return randWords[sel];
        return {1'b0, sel, 24'hA5A5A5};
    endfunction

    // Registered latch mux: output reflects the select seen at the previous edge.
    always @(posedge clk) begin
        dataA <= muxWord(selA);
        dataB <= muxWord(selB);
    end

    function automatic logic [6:0] gSel(input int w);  return (w != 0) ? selB : selA;     endfunction
    function automatic logic [7:0] gTx(input int w);   return (w != 0) ? txB : txA;       endfunction
    function automatic logic       gValid(input int w); return (w != 0) ? validB : validA; endfunction
    function automatic logic       gBusy(input int w);  return (w != 0) ? busyB : busyA;   endfunction
    function automatic logic       gDone(input int w);  return (w != 0) ? doneB : doneA;   endfunction

    task automatic setIn(input int w, input logic s, input logic a, input logic r);
        if (w != 0) begin
            startB = s; abortB = a; readyB = r;
        end else begin
            startA = s; abortA = a; readyA = r;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic buildExpected();
        logic [31:0] wd;
        for (int wi = 0; wi < NW; wi++) begin
            wd = muxWord(codeList[wi]);
            for (int b = 0; b < 4; b++) expBytes[wi*4 + b] = wd[8*b +: 8];
        end
    endtask

    task automatic checkByte(input int w, input int idx);
        if (idx < NW*4) checkOutput($sformatf("byte%0d", idx), gTx(w), expBytes[idx]);
        else            checkOutput("extraByte", idx, NW*4);
    endtask

    task automatic checkIdle(input int w, input string tag);
        checkOutput({tag, " tx_valid"}, gValid(w), 1'b0);
        checkOutput({tag, " busy"},     gBusy(w),  1'b0);
        checkOutput({tag, " mux_sel"},  gSel(w),   7'h00);
        checkOutput({tag, " tx_data"},  gTx(w),    8'h00);
        checkOutput({tag, " done"},     gDone(w),  1'b0);
    endtask

    // stopMode: 0 run to done, 1 abort at byte stopAt, 2 async reset at byte stopAt.
    task automatic applyStimulus(input int w, input int readyPct, input int stopMode, input int stopAt,
                                 input int lateStartWord, output int firstValidN, output int doneAt,
                                 output int bytesOut);
        int   n, bytes;
        bit   prevStall, lateFired, finished, rdy, st;
        logic [7:0] prevData;
        int   curWord;
        n = 0; bytes = 0; prevStall = 0; lateFired = 0; finished = 0; prevData = '0;
        firstValidN = -1; doneAt = -1;
        @(negedge clk); setIn(w, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        while (!finished) begin
            st = 0;
            if (gDone(w)) begin
                doneAt = n; finished = 1;
                setIn(w, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                checkOutput("donePulseWidth", gDone(w), 1'b0);
                checkOutput("idleAfterDone", gBusy(w), 1'b0);
            end else if (n > BUDGET) begin
                checkOutput("cycleBudget", n, BUDGET);
                setIn(w, 1'b0, 1'b0, 1'b0);
                finished = 1;
            end else begin
                if (firstValidN < 0 && gValid(w)) firstValidN = n;
                curWord = (bytes / 4 > NW - 1) ? NW - 1 : bytes / 4;
                checkOutput("busy", gBusy(w), 1'b1);
                checkOutput($sformatf("mux_sel word%0d", curWord), gSel(w), codeList[curWord]);
                if (prevStall) begin
                    checkOutput("stallValid", gValid(w), 1'b1);
                    checkOutput("stallData", gTx(w), prevData);
                end
                if (lateStartWord >= 0 && !lateFired && bytes >= lateStartWord*4 && gValid(w)) begin
                    st = 1; lateFired = 1;
                end
                rdy = ($urandom_range(99) < readyPct);
                if (stopMode != 0 && bytes == stopAt && gValid(w)) begin
                    finished = 1;
                    if (stopMode == 1) begin
                        setIn(w, 1'b0, 1'b1, rdy);
                        if (rdy) begin checkByte(w, bytes); bytes++; end
                        @(negedge clk);
                        setIn(w, 1'b0, 1'b0, 1'b0);
                        checkIdle(w, "afterAbort");
                        @(negedge clk);
                        checkOutput("noDoneAfterAbort", gDone(w), 1'b0);
                    end else begin
                        setIn(w, 1'b0, 1'b0, 1'b0);
                        #2 rst = 1'b0;
                        #1 checkIdle(w, "asyncReset");
                        @(negedge clk);
                        @(negedge clk);
                        rst = 1'b1;
                        @(negedge clk);
                        checkIdle(w, "afterReset");
                    end
                end else begin
                    setIn(w, st, 1'b0, rdy);
                    if (gValid(w) && rdy) begin checkByte(w, bytes); bytes++; end
                    prevStall = gValid(w) && !rdy;
                    prevData  = gTx(w);
                    @(negedge clk);
                    n++;
                end
            end
        end
        bytesOut = bytes;
    endtask

    initial begin
        checkCount = 0; passCount = 0; failCount = 0;
        codeList = '{7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
                     7'h20, 7'h21, 7'h23, 7'h24, 7'h25, 7'h26,
                     7'h30, 7'h31, 7'h32, 7'h33, 7'h40, 7'h41};
        useRand = 0;
        for (int i = 0; i < 128; i++) randWords[i] = $urandom;
        setIn(0, 1'b0, 1'b0, 1'b0);
        setIn(1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 rst = 1'b0;
        buildExpected();
        @(negedge clk);
        checkIdle(0, "resetA");
        checkIdle(1, "resetB");
        rst = 1'b1;

        $display("[TB] full dump, A5 pattern, ready always high");
        applyStimulus(0, 100, 0, 0, -1, firstV, doneN, nBytes);
        checkOutput("fullFirstValid", firstV, 2);
        checkOutput("fullDoneCycle", doneN + 1, 122);
        checkOutput("fullByteCount", nBytes, 80);

        useRand = 1;
        buildExpected();
        $display("[TB] backpressure, 30%% ready");
        applyStimulus(0, 30, 0, 0, -1, firstV, doneN, nBytes);
        checkOutput("bpByteCount", nBytes, 80);

        $display("[TB] abort at word 5 byte 2");
        applyStimulus(0, 50, 1, 5*4 + 2, -1, firstV, doneN, nBytes);

        $display("[TB] restart after abort");
        applyStimulus(0, 100, 0, 0, -1, firstV, doneN, nBytes);
        checkOutput("restartDoneCycle", doneN + 1, 122);
        checkOutput("restartByteCount", nBytes, 80);

        $display("[TB] start while busy at word 3");
        applyStimulus(0, 70, 0, 0, 3, firstV, doneN, nBytes);
        checkOutput("lateStartByteCount", nBytes, 80);

        $display("[TB] async reset mid-dump");
        applyStimulus(0, 60, 2, 7*4 + 1, -1, firstV, doneN, nBytes);
        applyStimulus(0, 100, 0, 0, -1, firstV, doneN, nBytes);
        checkOutput("postResetDoneCycle", doneN + 1, 122);
        checkOutput("postResetByteCount", nBytes, 80);

        $display("[TB] settle of 3 cycles");
        applyStimulus(1, 100, 0, 0, -1, firstV, doneN, nBytes);
        checkOutput("settle3FirstValid", firstV, 4);
        checkOutput("settle3DoneCycle", doneN + 1, 20*8 + 2);
        checkOutput("settle3ByteCount", nBytes, 80);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
